exponent_accelerator_pll_reset_ctrl: RTL
========================================

EXPONENT_ACCELERATOR_PLL_RESET_CTRL -- requirements
Module: exponent_accelerator_pll_reset_ctrl

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16: cycles pll_rst is held high per PLL reset attempt, range 2..255.
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles allowed for lock after pll_rst release, range 4..2^20.
REQ-003 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before releasing system reset, range 2..2^16.
REQ-004 Parameter MAX_RETRIES, default 3: lock timeouts tolerated before fault, range 0..15.
REQ-005 refclk  in  1  single clock for all logic; free-running reference clock, not a PLL output.
REQ-006 rst  in  1  asynchronous, active-high reset for all flops.
REQ-007 pll_locked  in  1  PLL locked indication; asynchronous to refclk.
REQ-008 fault_clr  in  1  single-cycle pulse; exits FAULT.
REQ-009 pll_rst  out  1  active-high reset to the PLL.
REQ-010 sys_rst  out  1  active-high reset to logic clocked by the PLL outputs.
REQ-011 ready  out  1  high only in RUN.
REQ-012 fault  out  1  high only in FAULT.
REQ-013 retry_count  out  4  lock timeouts in the current bring-up.
REQ-014 lock_loss_count  out  8  lock losses seen in RUN; saturates at 255.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer (locked_s); all decisions use locked_s only.
REQ-016 States SHALL be PLL_RESET, WAIT_LOCK, STABLE, RUN and FAULT; all outputs SHALL be registered.
REQ-017 PLL_RESET: pll_rst=1, sys_rst=1; after exactly PLL_RST_CYCLES cycles in state -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0, sys_rst=1; locked_s=1 -> STABLE with stable counter cleared.
REQ-019 WAIT_LOCK: locked_s still 0 after LOCK_TIMEOUT_CYCLES cycles in state -> timeout.
REQ-020 Timeout with retry_count<MAX_RETRIES: retry_count+1, -> PLL_RESET.
REQ-021 Timeout with retry_count==MAX_RETRIES: -> FAULT, retry_count unchanged.
REQ-022 STABLE: sys_rst=1; locked_s=1 for LOCK_STABLE_CYCLES consecutive cycles -> RUN.
REQ-023 STABLE: any locked_s=0 -> WAIT_LOCK with the timeout counter restarted at 0; no retry is counted.
REQ-024 RUN: sys_rst=0, ready=1, pll_rst=0; retry_count cleared on entry.
REQ-025 RUN: locked_s=0 -> PLL_RESET; lock_loss_count+1 (saturating).
REQ-026 Lock loss in RUN: sys_rst=1 and ready=0 on the first edge after locked_s=0 is sampled.
REQ-027 FAULT: pll_rst=1, sys_rst=1, fault=1, ready=0; pll_locked ignored.
REQ-028 fault_clr in FAULT: retry_count=0, -> PLL_RESET; fault_clr in any other state ignored.
REQ-029 sys_rst SHALL never be low unless in RUN; ready and fault SHALL never be high together.
REQ-030 Counters SHALL be sized for parameter maxima and SHALL be cleared on every state entry.

Reset
REQ-031 rst=1 SHALL immediately force state=PLL_RESET, pll_rst=1, sys_rst=1, ready=0, fault=0, all counters and synchronizer flops 0.
REQ-032 After rst deasserts, a full PLL_RST_CYCLES reset pulse SHALL start on the first refclk edge; lock_loss_count is cleared only by rst.
REQ-033 rst asserted in any state, including mid-count, SHALL behave identically to power-on reset.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-034 Nominal bring-up: release rst; raise pll_locked 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst falls and ready rises 2+8 (+1 register) cycles after pll_locked rises; retry_count=0.
REQ-035 Glitch in STABLE: drop pll_locked for 1 cycle 5 cycles into STABLE -> return to WAIT_LOCK; stable count restarts; sys_rst stays 1; retry_count unchanged.
REQ-036 Timeouts to fault: hold pll_locked=0 -> three 4-cycle pll_rst pulses, each followed by 32 WAIT_LOCK cycles; retry_count 1,2; then FAULT with fault=1, pll_rst=1, retry_count=2.
REQ-037 Fault recovery: pulse fault_clr in FAULT, then raise pll_locked -> fault=0, retry_count=0, normal bring-up to RUN.
REQ-038 Lock loss in RUN: drop pll_locked 300 times -> each drop asserts sys_rst 3 cycles later and relocks via PLL_RESET; lock_loss_count saturates at 255.
REQ-039 Async reset mid-STABLE: assert rst between edges -> outputs reach reset values without a refclk edge; bring-up restarts from PLL_RESET.

Source files
------------

// File: rtl/exponent_accelerator_pll_reset_ctrl.sv
// PLL bring-up sequencer: pulses pll_rst, waits for a synchronized, stable lock,
// then releases sys_rst. Retries on lock timeout and parks in FAULT when retries run out.
module exponent_accelerator_pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       fault_clr,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state_dbg
);

  localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                   : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX   = (LOCK_TIMEOUT_CYCLES > CNT_MAX_A) ? LOCK_TIMEOUT_CYCLES : CNT_MAX_A;
  localparam int CW        = $clog2(CNT_MAX);

  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [3:0]    retry_next;
  logic [7:0]    llc_next;
  logic          sync1;
  logic          locked_s;
  logic          pll_rst_d;
  logic          sys_rst_d;
  logic          ready_d;
  logic          fault_d;

  assign state_dbg = state;

  // pll_locked comes from the PLL's own domain; only locked_s is ever looked at.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state           <= PLL_RESET;
      cnt             <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      pll_rst         <= 1'b1;
      sys_rst         <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      retry_count     <= retry_next;
      lock_loss_count <= llc_next;
      pll_rst         <= pll_rst_d;
      sys_rst         <= sys_rst_d;
      ready           <= ready_d;
      fault           <= fault_d;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    retry_next = retry_count;
    llc_next   = lock_loss_count;
    case (state)
      PLL_RESET: begin
        if (cnt == PLL_RST_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_count < RETRY_MAX) begin
            retry_next = retry_count + 4'd1;
            state_next = PLL_RESET;
          end else begin
            state_next = FAULT;
          end
        end
      end
      STABLE: begin
        // A single unlocked sample restarts the lock wait without costing a retry.
        if (!locked_s) state_next = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_next = RUN;
      end
      RUN: begin
        cnt_next = '0;
        if (!locked_s) begin
          state_next = PLL_RESET;
          if (lock_loss_count != 8'hFF) llc_next = lock_loss_count + 8'd1;
        end
      end
      FAULT: begin
        cnt_next = '0;
        if (fault_clr) begin
          retry_next = '0;
          state_next = PLL_RESET;
        end
      end
      default: state_next = PLL_RESET;
    endcase
    if (state_next != state) cnt_next = '0;
    if (state_next == RUN && state != RUN) retry_next = '0;
  end

  // Outputs decode the next state so the registered copies line up with state.
  always_comb begin
    pll_rst_d = 1'b0;
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    case (state_next)
      PLL_RESET: pll_rst_d = 1'b1;
      RUN: begin
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      FAULT: begin
        pll_rst_d = 1'b1;
        fault_d   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
